// File: rtl/branch_target_predictor_pkg.sv
// Shared datapath and branch-prediction types for the fetch/execute pipeline.
package BasicTypes;
  typedef logic [31:0] BasicData;
endpackage

package PipelineTypes;
  import BasicTypes::*;

  localparam int BTB_ENTRY_NUM           = 16;
  localparam int BTB_ENTRY_NUM_BIT_WIDTH = $clog2(BTB_ENTRY_NUM);
  localparam int BTB_TAG_WIDTH           = 32 - BTB_ENTRY_NUM_BIT_WIDTH - 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } BranchCounter;

  function automatic BranchCounter counter_update(input BranchCounter c, input logic taken);
    if (taken) return (c == STRONG_T) ? STRONG_T : BranchCounter'(c + 2'd1);
    else       return (c == STRONG_NT) ? STRONG_NT : BranchCounter'(c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_target_predictor_bht.sv
// Tagged target/counter table: combinational lookup, falling-edge update.
// Writes land at the edge, so a same-cycle lookup of the written index sees old contents.
module branch_history_table
  import BasicTypes::*;
  import PipelineTypes::*;
#(
  parameter int ENTRIES = BTB_ENTRY_NUM
) (
  input  logic         clk,
  input  logic         rst,
  input  BasicData     rd_pc,
  output logic         rd_hit,
  output BranchCounter rd_ctr,
  output BasicData     rd_target,
  input  logic         upd_vld,
  input  BasicData     upd_pc,
  input  logic         upd_taken,
  input  BasicData     upd_target
);
  localparam int IDX_W = (ENTRIES == BTB_ENTRY_NUM) ? BTB_ENTRY_NUM_BIT_WIDTH : $clog2(ENTRIES);
  localparam int TAG_W = (ENTRIES == BTB_ENTRY_NUM) ? BTB_TAG_WIDTH : 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  BasicData         target_q [ENTRIES];
  BasicData         target_d [ENTRIES];
  BranchCounter     ctr_q    [ENTRIES];
  BranchCounter     ctr_d    [ENTRIES];

  logic [IDX_W-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;
  logic             upd_hit;
  logic             unused_pc_lsbs;

  assign rd_idx         = rd_pc[IDX_W+1:2];
  assign rd_tag         = rd_pc[31:IDX_W+2];
  assign upd_idx        = upd_pc[IDX_W+1:2];
  assign upd_tag        = upd_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^{rd_pc[1:0], upd_pc[1:0]};

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_ctr    = ctr_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_vld) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = counter_update(ctr_q[upd_idx], upd_taken);
        if (upd_taken) target_d[upd_idx] = upd_target;
      end else if (upd_taken) begin
        // Miss on a taken branch evicts whatever aliased into this slot.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = WEAK_T;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WEAK_NT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end
endmodule

// File: rtl/branch_target_predictor.sv
// Branch target predictor: 0-cycle next-PC prediction, resolve compare/redirect, statistics.
// State updates on the falling clock edge; a stalled execute stage leaves everything untouched.
module branch_target_predictor
  import BasicTypes::*;
  import PipelineTypes::*;
#(
  parameter int ENTRIES = BTB_ENTRY_NUM
) (
  input  logic     clk,
  input  logic     rst,
  input  BasicData fetchPc,
  output BasicData predNextPc,
  output logic     predTaken,
  output logic     predHit,
  input  logic     exIsBranch,
  input  logic     exBranchTaken,
  input  BasicData exPc,
  input  BasicData exIrregPc,
  input  BasicData exPredNextPc,
  input  logic     exStall,
  output logic     mispredict,
  output BasicData redirectPc,
  output BasicData branchCount,
  output BasicData mispredCount
);
  BranchCounter rd_ctr;
  BasicData     rd_target, correct_next;
  logic         resolve_vld;
  BasicData     branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  branch_history_table #(.ENTRIES(ENTRIES)) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_pc      (fetchPc),
    .rd_hit     (predHit),
    .rd_ctr     (rd_ctr),
    .rd_target  (rd_target),
    .upd_vld    (resolve_vld),
    .upd_pc     (exPc),
    .upd_taken  (exBranchTaken),
    .upd_target (exIrregPc)
  );

  assign predTaken  = predHit && rd_ctr[1];
  assign predNextPc = predTaken ? rd_target : fetchPc + 32'd4;

  assign correct_next = exBranchTaken ? exIrregPc : exPc + 32'd4;
  assign redirectPc   = correct_next;
  assign resolve_vld  = rst && exIsBranch && !exStall;
  assign mispredict   = resolve_vld && (exPredNextPc != correct_next);

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve_vld && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branchCount  = branch_cnt_q;
  assign mispredCount = mispred_cnt_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized and directed checks of branch_target_predictor against a table-level reference model.
module tb_branch_target_predictor;
  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic [31:0] fetchPc, predNextPc, exPc, exIrregPc, exPredNextPc, redirectPc, branchCount, mispredCount;
  logic        predTaken, predHit, exIsBranch, exBranchTaken, exStall, mispredict;

  branch_target_predictor #(.ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .fetchPc(fetchPc), .predNextPc(predNextPc), .predTaken(predTaken),
    .predHit(predHit), .exIsBranch(exIsBranch), .exBranchTaken(exBranchTaken), .exPc(exPc),
    .exIrregPc(exIrregPc), .exPredNextPc(exPredNextPc), .exStall(exStall), .mispredict(mispredict),
    .redirectPc(redirectPc), .branchCount(branchCount), .mispredCount(mispredCount)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [31:0] m_bcnt, m_mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 6));
  endfunction

  function automatic logic [31:0] m_pred(input logic [31:0] pc);
    if (m_hit(pc) && m_ctr[m_idx(pc)] >= 2) return m_tgt[m_idx(pc)];
    return pc + 32'd4;
  endfunction

  // One cycle: apply inputs, check combinational outputs, then let the falling edge commit.
  task automatic drive(input logic r, input logic [31:0] f, input logic isb, input logic tk,
                       input logic [31:0] pc, input logic [31:0] irr, input logic [31:0] pn,
                       input logic st);
    logic [31:0] cn;
    bit          res, mp, eh;
    int          ei;
    rst = r; fetchPc = f; exIsBranch = isb; exBranchTaken = tk;
    exPc = pc; exIrregPc = irr; exPredNextPc = pn; exStall = st;
    #1;
    cn  = tk ? irr : pc + 32'd4;
    res = r && isb && !st;
    mp  = res && (pn != cn);
    chk("pred_hit", {31'd0, predHit}, {31'd0, m_hit(f)});
    chk("pred_taken", {31'd0, predTaken}, {31'd0, m_hit(f) && m_ctr[m_idx(f)] >= 2});
    chk("pred_next_pc", predNextPc, m_pred(f));
    chk("mispredict", {31'd0, mispredict}, {31'd0, mp});
    chk("redirect_pc", redirectPc, cn);
    chk("branch_count", branchCount, m_bcnt);
    chk("mispred_count", mispredCount, m_mcnt);
    @(negedge clk);
    if (!r) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_bcnt = 0; m_mcnt = 0;
    end else if (res) begin
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
      if (mp && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
      ei = m_idx(pc);
      eh = m_hit(pc);
      if (eh) begin
        m_ctr[ei] = tk ? ((m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1) : ((m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1);
        if (tk) m_tgt[ei] = irr;
      end else if (tk) begin
        m_valid[ei] = 1; m_tag[ei] = pc >> 6; m_tgt[ei] = irr; m_ctr[ei] = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rpc, rirr, rpn, rf;
  logic        rtk;

  initial begin
    m_bcnt = 0; m_mcnt = 0;
    rst = 1'b0; fetchPc = 0; exIsBranch = 0; exBranchTaken = 0;
    exPc = 0; exIrregPc = 0; exPredNextPc = 0; exStall = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    @(negedge clk); @(posedge clk); #1;

    drive(0, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("reset_next_pc", predNextPc, 32'h104);
    chk("reset_counts", branchCount | mispredCount, 32'h0);

    // Allocation on a taken miss, then the entry predicts the next cycle.
    drive(1, 32'h100, 1, 1, 32'h100, 32'h200, 32'h104, 0);
    chk("alloc_pred_next", predNextPc, 32'h200);
    chk("alloc_mispred_cnt", mispredCount, 32'h1);
    drive(1, 32'h100, 1, 1, 32'h100, 32'h200, 32'h200, 0);
    drive(1, 32'h100, 1, 1, 32'h100, 32'h200, 32'h200, 0);
    drive(1, 32'h100, 1, 1, 32'h100, 32'h200, 32'h200, 0);
    drive(1, 32'h100, 1, 0, 32'h100, 32'h200, 32'h200, 0);
    drive(1, 32'h100, 1, 0, 32'h100, 32'h200, 32'h200, 0);
    chk("weak_nt_next_pc", predNextPc, 32'h104);
    chk("weak_nt_hit", {31'd0, predHit}, 32'h1);

    // Aliasing: 0x140 shares slot 0 with 0x100.
    drive(1, 32'h140, 1, 1, 32'h140, 32'h300, 32'h144, 0);
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h140, 0, 0, 0, 0, 0, 0);

    // Stalled resolve and a resolve under reset are both dropped.
    drive(1, 32'h180, 1, 1, 32'h180, 32'h400, 32'h184, 1);
    drive(0, 32'h180, 1, 1, 32'h180, 32'h400, 32'h184, 0);
    drive(1, 32'h180, 0, 0, 0, 0, 0, 0);
    chk("rst_resolve_count", branchCount, 32'h0);

    // Wrap-around and mispredict counter saturation.
    drive(1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 32'h10, 32'h10, 0);
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt_q;
    m_mcnt = 32'hFFFF_FFFF;
    drive(1, 32'h0, 1, 1, 32'h40, 32'h80, 32'h44, 0);
    drive(1, 32'h40, 1, 0, 32'h40, 32'h80, 32'h80, 0);
    chk("mispred_saturated", mispredCount, 32'hFFFF_FFFF);

    for (int n = 0; n < 400; n++) begin
      rpc  = ($urandom_range(0, 1) ? 32'h0 : 32'hFFFF_FF00) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      rf   = ($urandom_range(0, 1) ? 32'h0 : 32'hFFFF_FF00) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      rirr = {$urandom_range(0, 7), 2'b00} << 4;
      rtk  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       rpn = m_pred(rpc);
        1:       rpn = rpc + 32'd4;
        default: rpn = rirr;
      endcase
      drive(($urandom_range(0, 39) != 0), rf, ($urandom_range(0, 4) != 0), rtk, rpc, rirr, rpn,
            ($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, power of two; number of prediction table entries.
REQ-002 SHALL have ports: clk  in  1  single clock; all state updates on the falling edge, same as pipeline registers.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: fetchPc  in  32  PC being fetched.
REQ-005 SHALL have ports: predNextPc  out  32  predicted next PC; predTaken  out  1  predicted taken; predHit  out  1  table hit (next PC predicted).
REQ-006 SHALL have ports: exIsBranch  in  1  resolved instruction is a branch or jump; exBranchTaken  in  1  actual direction.
REQ-007 SHALL have ports: exPc  in  32  resolved PC; exIrregPc  in  32  resolved taken target; exPredNextPc  in  32  next PC predicted for that instruction.
REQ-008 SHALL have ports: exStall  in  1  execute stage held; resolution not consumed.
REQ-009 SHALL have ports: mispredict  out  1  redirect request; redirectPc  out  32  correct next PC.
REQ-010 SHALL have ports: branchCount  out  32  resolved branch count; mispredCount  out  32  misprediction count.

Function
REQ-011 SHALL use idx = PC[log2(ENTRIES)+1:2], tag = PC[31:log2(ENTRIES)+2]; each entry holds valid, tag, 32-bit target, 2-bit counter.
REQ-012 SHALL predict combinationally (0-cycle latency): predHit = valid[idx] && tag match; predTaken = predHit && counter[1]; predNextPc = predTaken ? target : fetchPc+4.
REQ-013 SHALL compute correctNext = exBranchTaken ? exIrregPc : exPc+4; redirectPc = correctNext always.
REQ-014 SHALL assert mispredict combinationally iff rst=1, exIsBranch=1, exStall=0 and exPredNextPc != correctNext.
REQ-015 On a resolve (exIsBranch=1, exStall=0) that hits at exPc: counter increments on taken, decrements on not-taken, saturating at 3 and 0; target := exIrregPc if taken.
REQ-016 On a resolve that misses: if taken, allocate (overwrite) the entry: valid=1, tag, target=exIrregPc, counter=2 (weakly taken); if not taken, no table change.
REQ-017 SHALL make a table write visible to prediction from the next cycle only; a same-cycle fetch at the written index sees the old contents.
REQ-018 SHALL ignore exBranchTaken, exPc, exIrregPc and exPredNextPc when exIsBranch=0 or exStall=1: no update, no count, mispredict=0.
REQ-019 SHALL increment branchCount per resolve and mispredCount per cycle with mispredict=1; both saturate at 0xFFFF_FFFF.
REQ-020 SHALL give PC+4 wrap-around modulo 2^32 (0xFFFF_FFFC+4 = 0).

Reset
REQ-021 While rst=0 at a clock edge: all valid=0, counters=1 (weakly not-taken), targets=0, branchCount=mispredCount=0.
REQ-022 While rst=0, mispredict=0; prediction outputs derive from the (cleared) table, so predHit=0 and predNextPc=fetchPc+4.
REQ-023 A resolve coincident with rst=0 SHALL be discarded; a reset mid-operation loses all history.

Structure
REQ-024 SHALL place BTB_ENTRY_NUM, index/tag width constants and the 2-bit BranchCounter typedef (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T) in PipelineTypes; 32-bit data uses BasicData from BasicTypes.
REQ-025 SHALL isolate the entry array and its read/update logic in one sub-module, branch_history_table; compare and count logic stays at top level.

Verification
REQ-026 After reset, fetchPc=0x100 -> predHit=0, predTaken=0, predNextPc=0x104, counters 0.
REQ-027 Resolve exPc=0x100 taken, exIrregPc=0x200, exPredNextPc=0x104 -> mispredict=1, redirectPc=0x200; next cycle fetchPc=0x100 -> predHit=1, predTaken=1, predNextPc=0x200.
REQ-028 Three more taken resolves at 0x100, then two not-taken (exPredNextPc=0x200) -> each not-taken gives mispredict=1, redirectPc=0x104; the counter goes 3->2->1, then predTaken=0 and predNextPc=0x104.
REQ-029 Aliasing case: resolve exPc=0x140 (same idx as 0x100 for ENTRIES=16) taken to 0x300 -> entry replaced; fetch 0x100 -> predHit=0; fetch 0x140 -> predNextPc=0x300.
REQ-030 Stall case: exStall=1 with a mispredicting resolve -> mispredict=0, counts unchanged, table unchanged; rst=0 in the same cycle as a resolve -> no allocation and counts stay 0.
REQ-031 Saturation and wrap: preload mispredCount=0xFFFFFFFF via forced state, mispredict -> stays 0xFFFFFFFF; exPc=0xFFFFFFFC not-taken -> redirectPc=0x0.
